// File: rtl/parking_lane_arbiter.sv
// rtl/parking_lane_arbiter.sv - one barrier gate shared by a PIN-checked entry lane and an exit lane
module parking_lane_arbiter #(
  parameter int CAPACITY  = 8,
  parameter int CNT_W     = 4,
  parameter int MAX_TRIES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entry_vehicle,
  input  logic [15:0]      entry_pin,
  input  logic             entry_pin_valid,
  input  logic             exit_vehicle,
  input  logic             vehicle_passed,
  input  logic [15:0]      correct_password,
  input  logic             admin_clear,
  output logic             open_gate,
  output logic             close_gate,
  output logic             grant_entry,
  output logic             grant_exit,
  output logic [CNT_W-1:0] occupancy,
  output logic             lot_full,
  output logic             alarm_wrong_pin,
  output logic             alarm_blocked
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ENTRY_PIN  = 3'd1,
    S_ENTRY_OPEN = 3'd2,
    S_EXIT_OPEN  = 3'd3,
    S_BLOCKED    = 3'd4
  } state_t;

  localparam int                FAIL_W  = $clog2(MAX_TRIES + 1);
  localparam logic [CNT_W-1:0]  CAP_V   = CNT_W'(CAPACITY);
  localparam logic [FAIL_W-1:0] TRIES_V = FAIL_W'(MAX_TRIES);

  state_t            state_q, state_d;
  logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_d, fail_inc;
  logic              entry_locked_q, entry_locked_d;
  logic              last_exit_q, last_exit_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic              open_q, open_d;
  logic              close_q, close_d;
  logic              gnt_entry_q, gnt_entry_d;
  logic              gnt_exit_q, gnt_exit_d;
  logic              blocked_q, blocked_d;
  logic              entry_elig, exit_elig;

  // Lane eligibility: never grant a lane whose pass would wrap the occupancy counter
  assign entry_elig = entry_vehicle && !entry_locked_q && (occ_q != CAP_V);
  assign exit_elig  = exit_vehicle && (occ_q != '0);
  assign fail_inc   = fail_cnt_q + FAIL_W'(1);

  // State register plus the bookkeeping that moves with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      fail_cnt_q     <= '0;
      entry_locked_q <= 1'b0;
      last_exit_q    <= 1'b1;
      occ_q          <= '0;
    end else begin
      state_q        <= state_d;
      fail_cnt_q     <= fail_cnt_d;
      entry_locked_q <= entry_locked_d;
      last_exit_q    <= last_exit_d;
      occ_q          <= occ_d;
    end
  end

  // Next-state logic; operator clear pre-empts any lane transition in that cycle
  always_comb begin
    state_d        = state_q;
    fail_cnt_d     = fail_cnt_q;
    entry_locked_d = entry_locked_q;
    last_exit_d    = last_exit_q;
    occ_d          = occ_q;
    if (admin_clear) begin
      fail_cnt_d     = '0;
      entry_locked_d = 1'b0;
      if (state_q == S_BLOCKED) state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (entry_elig && (!exit_elig || last_exit_q)) state_d = S_ENTRY_PIN;
          else if (exit_elig)                            state_d = S_EXIT_OPEN;
        end
        S_ENTRY_PIN: begin
          if (!entry_vehicle) begin
            state_d = S_IDLE;
          end else if (entry_pin_valid) begin
            if (entry_pin == correct_password) begin
              state_d    = S_ENTRY_OPEN;
              fail_cnt_d = '0;
            end else begin
              fail_cnt_d = fail_inc;
              if (fail_inc == TRIES_V) begin
                entry_locked_d = 1'b1;
                state_d        = S_IDLE;
              end
            end
          end
        end
        S_ENTRY_OPEN: begin
          if (vehicle_passed) begin
            occ_d       = occ_q + CNT_W'(1);
            last_exit_d = 1'b0;
            state_d     = entry_vehicle ? S_BLOCKED : S_IDLE;
          end else if (!entry_vehicle) begin
            state_d = S_IDLE;
          end
        end
        S_EXIT_OPEN: begin
          if (vehicle_passed) begin
            occ_d       = occ_q - CNT_W'(1);
            last_exit_d = 1'b1;
            state_d     = exit_vehicle ? S_BLOCKED : S_IDLE;
          end else if (!exit_vehicle) begin
            state_d = S_IDLE;
          end
        end
        S_BLOCKED: state_d = S_BLOCKED;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from the next state so the registered outputs line up with state_q
  always_comb begin
    open_d      = 1'b0;
    close_d     = 1'b1;
    gnt_entry_d = 1'b0;
    gnt_exit_d  = 1'b0;
    blocked_d   = 1'b0;
    case (state_d)
      S_ENTRY_PIN:  gnt_entry_d = 1'b1;
      S_ENTRY_OPEN: begin
        gnt_entry_d = 1'b1;
        open_d      = 1'b1;
        close_d     = 1'b0;
      end
      S_EXIT_OPEN: begin
        gnt_exit_d = 1'b1;
        open_d     = 1'b1;
        close_d    = 1'b0;
      end
      S_BLOCKED:    blocked_d = 1'b1;
      default:      ;
    endcase
  end

  // Output registers; reset leaves the gate driven closed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      open_q      <= 1'b0;
      close_q     <= 1'b1;
      gnt_entry_q <= 1'b0;
      gnt_exit_q  <= 1'b0;
      blocked_q   <= 1'b0;
    end else begin
      open_q      <= open_d;
      close_q     <= close_d;
      gnt_entry_q <= gnt_entry_d;
      gnt_exit_q  <= gnt_exit_d;
      blocked_q   <= blocked_d;
    end
  end

  assign open_gate       = open_q;
  assign close_gate      = close_q;
  assign grant_entry     = gnt_entry_q;
  assign grant_exit      = gnt_exit_q;
  assign alarm_blocked   = blocked_q;
  assign alarm_wrong_pin = entry_locked_q;
  assign occupancy       = occ_q;
  assign lot_full        = (occ_q == CAP_V);

endmodule

// File: tb/tb_parking_lane_arbiter.sv
// tb/tb_parking_lane_arbiter.sv - self-checking bench for parking_lane_arbiter against a lane-ownership model
module tb_parking_lane_arbiter;
  localparam int CAP  = 8;
  localparam int MAXT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        entry_vehicle, entry_pin_valid, exit_vehicle, vehicle_passed, admin_clear;
  logic [15:0] entry_pin, correct_password;
  logic        open_gate, close_gate, grant_entry, grant_exit, lot_full;
  logic        alarm_wrong_pin, alarm_blocked;
  logic [3:0]  occupancy;

  parking_lane_arbiter #(.CAPACITY(CAP), .CNT_W(4), .MAX_TRIES(MAXT)) dut (
    .clk(clk), .rst(rst),
    .entry_vehicle(entry_vehicle), .entry_pin(entry_pin), .entry_pin_valid(entry_pin_valid),
    .exit_vehicle(exit_vehicle), .vehicle_passed(vehicle_passed),
    .correct_password(correct_password), .admin_clear(admin_clear),
    .open_gate(open_gate), .close_gate(close_gate),
    .grant_entry(grant_entry), .grant_exit(grant_exit),
    .occupancy(occupancy), .lot_full(lot_full),
    .alarm_wrong_pin(alarm_wrong_pin), .alarm_blocked(alarm_blocked)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: who owns the gate (0 nobody, 1 entry, 2 exit), whether the barrier is up,
  // whether it is frozen by a tailgate, plus counters.
  int m_owner, m_occ, m_fails;
  bit m_up, m_frozen, m_locked, m_last_exit;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_occ = 0; m_fails = 0;
    m_up = 0; m_frozen = 0; m_locked = 0; m_last_exit = 1;
  endtask

  task automatic model_step();
    bit e, x, present;
    if (rst) begin model_reset(); return; end
    if (admin_clear) begin
      m_fails = 0; m_locked = 0; m_frozen = 0;
      return;
    end
    if (m_frozen) return;
    if (m_owner == 0) begin
      e = entry_vehicle && !m_locked && (m_occ < CAP);
      x = exit_vehicle && (m_occ > 0);
      if (e && x)  m_owner = m_last_exit ? 1 : 2;
      else if (e)  m_owner = 1;
      else if (x)  m_owner = 2;
      m_up = (m_owner == 2);
    end else if (!m_up) begin
      if (!entry_vehicle) m_owner = 0;
      else if (entry_pin_valid) begin
        if (entry_pin == correct_password) begin
          m_up = 1; m_fails = 0;
        end else begin
          m_fails++;
          if (m_fails >= MAXT) begin m_locked = 1; m_owner = 0; end
        end
      end
    end else begin
      present = (m_owner == 1) ? entry_vehicle : exit_vehicle;
      if (vehicle_passed) begin
        m_occ       = m_occ + ((m_owner == 1) ? 1 : -1);
        m_last_exit = (m_owner == 2);
        m_frozen    = present;
        m_owner     = 0;
        m_up        = 0;
      end else if (!present) begin
        m_owner = 0;
        m_up    = 0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic quiet();
    entry_vehicle = 0; exit_vehicle = 0; vehicle_passed = 0;
    entry_pin_valid = 0; admin_clear = 0; entry_pin = 16'h0000;
  endtask

  task automatic do_entry();
    entry_vehicle = 1; exit_vehicle = 0; cyc();
    entry_pin = correct_password; entry_pin_valid = 1; cyc();
    entry_pin_valid = 0; entry_vehicle = 0; vehicle_passed = 1; cyc();
    vehicle_passed = 0; cyc();
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int d = 0; d < 4; d++) v[d*4 +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Every cycle: DUT outputs against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("open_gate",       32'(open_gate),       32'(m_up));
      chk("close_gate",      32'(close_gate),      32'(!m_up));
      chk("grant_entry",     32'(grant_entry),     32'(m_owner == 1));
      chk("grant_exit",      32'(grant_exit),      32'(m_owner == 2));
      chk("occupancy",       32'(occupancy),       32'(m_occ));
      chk("lot_full",        32'(lot_full),        32'(m_occ == CAP));
      chk("alarm_wrong_pin", 32'(alarm_wrong_pin), 32'(m_locked));
      chk("alarm_blocked",   32'(alarm_blocked),   32'(m_frozen));
    end
  end

  initial begin
    quiet();
    correct_password = 16'h3761;
    rst = 1;
    model_reset();
    cyc(); cyc();
    rst = 0;
    cyc();
    chk_en = 1;

    chk("rst_close", 32'(close_gate), 32'd1);
    chk("rst_open",  32'(open_gate),  32'd0);
    chk("rst_grant", 32'({grant_entry, grant_exit}), 32'd0);
    chk("rst_occ",   32'(occupancy),  32'd0);
    chk("rst_alarm", 32'({alarm_wrong_pin, alarm_blocked}), 32'd0);

    entry_vehicle = 1; cyc();
    chk("t1_grant_entry", 32'(grant_entry), 32'd1);
    entry_pin = 16'h3761; entry_pin_valid = 1; cyc();
    entry_pin_valid = 0;
    chk("t1_open", 32'(open_gate), 32'd1);
    entry_vehicle = 0; vehicle_passed = 1; cyc();
    vehicle_passed = 0;
    chk("t1_occ",   32'(occupancy),  32'd1);
    chk("t1_close", 32'(close_gate), 32'd1);

    entry_vehicle = 1; cyc();
    entry_pin_valid = 1;
    entry_pin = 16'h1234; cyc();
    entry_pin = 16'h1235; cyc();
    chk("t2_not_locked_yet", 32'(alarm_wrong_pin), 32'd0);
    entry_pin = 16'h1368; cyc();
    entry_pin_valid = 0;
    chk("t2_locked",     32'(alarm_wrong_pin), 32'd1);
    chk("t2_back_idle",  32'(grant_entry),     32'd0);
    cyc();
    chk("t2_entry_ignored", 32'(grant_entry), 32'd0);
    entry_vehicle = 0; exit_vehicle = 1; cyc();
    chk("t2_exit_served", 32'(grant_exit), 32'd1);
    exit_vehicle = 0; vehicle_passed = 1; cyc();
    vehicle_passed = 0;
    chk("t2_occ", 32'(occupancy), 32'd0);
    admin_clear = 1; cyc();
    admin_clear = 0;
    chk("t2_cleared", 32'(alarm_wrong_pin), 32'd0);

    entry_vehicle = 1; cyc();
    entry_pin = 16'h3761; entry_pin_valid = 1; cyc();
    entry_pin_valid = 0; vehicle_passed = 1; cyc();
    vehicle_passed = 0;
    chk("t3_blocked", 32'(alarm_blocked), 32'd1);
    chk("t3_closed",  32'(close_gate),    32'd1);
    chk("t3_occ",     32'(occupancy),     32'd1);
    exit_vehicle = 1; cyc(); cyc();
    chk("t3_ignored", 32'({grant_entry, grant_exit}), 32'd0);
    quiet(); admin_clear = 1; cyc();
    admin_clear = 0;
    chk("t3_unblocked", 32'(alarm_blocked), 32'd0);

    do_entry();
    chk("t4_occ2", 32'(occupancy), 32'd2);
    for (int k = 0; k < 3; k++) begin
      entry_vehicle = 1; exit_vehicle = 1; cyc();
      chk("t4_alt_entry", 32'(grant_entry), 32'(k == 1));
      chk("t4_alt_exit",  32'(grant_exit),  32'(k != 1));
      if (k == 1) begin
        entry_pin = correct_password; entry_pin_valid = 1; cyc();
        entry_pin_valid = 0; entry_vehicle = 0;
      end else begin
        exit_vehicle = 0;
      end
      vehicle_passed = 1; cyc();
      vehicle_passed = 0;
    end
    quiet(); cyc();
    chk("t4_occ_end", 32'(occupancy), 32'd1);

    for (int k = 0; k < 7; k++) do_entry();
    chk("t5_occ8", 32'(occupancy), 32'd8);
    chk("t5_full", 32'(lot_full),  32'd1);
    entry_vehicle = 1; cyc(); cyc();
    chk("t5_no_entry", 32'(grant_entry), 32'd0);
    entry_vehicle = 0; exit_vehicle = 1; cyc();
    chk("t5_exit", 32'(grant_exit), 32'd1);
    exit_vehicle = 0; vehicle_passed = 1; cyc();
    vehicle_passed = 0;
    chk("t5_occ7",    32'(occupancy), 32'd7);
    chk("t5_notfull", 32'(lot_full),  32'd0);
    entry_vehicle = 1; cyc();
    chk("t5_entry_again", 32'(grant_entry), 32'd1);
    entry_vehicle = 0; cyc();

    exit_vehicle = 1; cyc();
    chk("t6_exit_open", 32'(open_gate), 32'd1);
    #2 rst = 1;
    #1;
    chk("t6_async_open",  32'(open_gate),  32'd0);
    chk("t6_async_close", 32'(close_gate), 32'd1);
    chk("t6_async_occ",   32'(occupancy),  32'd0);
    chk("t6_async_grant", 32'(grant_exit), 32'd0);
    model_reset();
    exit_vehicle = 0;
    cyc();
    rst = 0;
    cyc();

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 199) == 0) correct_password = rand_bcd();
      entry_vehicle   = ($urandom_range(0, 9) < 7);
      exit_vehicle    = ($urandom_range(0, 9) < 6);
      vehicle_passed  = ($urandom_range(0, 9) < 3);
      entry_pin_valid = ($urandom_range(0, 9) < 4);
      entry_pin       = ($urandom_range(0, 1) == 1) ? correct_password : rand_bcd();
      admin_clear     = ($urandom_range(0, 49) == 0);
      rst             = ($urandom_range(0, 599) == 0);
      if (rst) model_reset();
      cyc();
    end
    rst = 0;
    quiet();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
